// File: rtl/clkdiv_bank.sv
// clkdiv_bank: a bank of NUM_CH clock dividers that run independently from one
// fabric clock. The divisor and high-time of each channel can be changed at
// runtime.
//
// Each channel holds two configurations. The active one (act_div, act_high)
// drives the counter. The shadow one (sh_div, sh_high) holds a pending write.
// A shadow value is copied into the active registers only at a period
// boundary, so a reprogrammed clock never gets a short or torn period.
//
// Ports:
//   clk_in   fabric clock; all logic runs on its rising edge
//   rst      synchronous reset, active high
//   en       per-channel run enable
//   sync     restarts every enabled channel at the start of its period
//   wr_en    single-cycle config write strobe
//   wr_ch    channel to write; values >= NUM_CH are ignored
//   wr_div   new divisor (period length in clk_in cycles); 0 and 1 are stored as 2
//   wr_high  new high-count (number of clk_out high cycles per period)
//   clk_out  registered divided clock, one bit per channel
//   tick     registered one-cycle pulse at the start of each period

module clkdiv_bank #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 8,
    parameter int DEFAULT_DIV  = 8,
    parameter int DEFAULT_HIGH = 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [CNT_W-1:0]  wr_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0] cnt      [NUM_CH];
    logic [CNT_W-1:0] act_div  [NUM_CH];
    logic [CNT_W-1:0] act_high [NUM_CH];
    logic [CNT_W-1:0] sh_div   [NUM_CH];
    logic [CNT_W-1:0] sh_high  [NUM_CH];
    logic [NUM_CH-1:0] pend;

    logic [CNT_W-1:0]  wr_div_c;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] bnd;

    // An index that is out of range matches no channel, so the write is dropped.
    // The wrap test uses >=, so a count that somehow lands past the period end
    // still wraps back to 0 on the next edge.
    always_comb begin
        wr_div_c = (wr_div < CNT_W'(2)) ? CNT_W'(2) : wr_div;
        wr_hit   = '0;
        bnd      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_en && (wr_ch == CH_W'(i));
            bnd[i]    = !en[i] || sync || (cnt[i] >= act_div[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pend    <= '0;
            clk_out <= '0;
            tick    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                act_div[i]  <= CNT_W'(DEFAULT_DIV);
                act_high[i] <= CNT_W'(DEFAULT_HIGH);
                sh_div[i]   <= CNT_W'(DEFAULT_DIV);
                sh_high[i]  <= CNT_W'(DEFAULT_HIGH);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Outputs are computed from the count as it stands before this edge.
                clk_out[i] <= en[i] && (cnt[i] < act_high[i]);
                tick[i]    <= en[i] && (cnt[i] == '0);

                if (wr_hit[i]) begin
                    sh_div[i]  <= wr_div_c;
                    sh_high[i] <= wr_high;
                end

                if (bnd[i]) begin
                    // A write that arrives in the boundary cycle itself replaces
                    // whatever is waiting in the shadow registers.
                    if (wr_hit[i]) begin
                        act_div[i]  <= wr_div_c;
                        act_high[i] <= wr_high;
                    end else if (pend[i]) begin
                        act_div[i]  <= sh_div[i];
                        act_high[i] <= sh_high[i];
                    end
                    pend[i] <= 1'b0;
                    cnt[i]  <= '0;
                end else begin
                    if (wr_hit[i]) begin
                        pend[i] <= 1'b1;
                    end
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank (NUM_CH=4, CNT_W=8, defaults 8/4).
// The reference model tracks each channel's position within its period and
// its active/pending configuration. Outputs are checked every cycle.

module tb_clkdiv_bank;

    localparam int NCH = 4;

    logic           clk_in = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           sync;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [7:0]     wr_div;
    logic [7:0]     wr_high;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // model state
    int m_ph   [NCH];
    int m_div  [NCH];
    int m_high [NCH];
    int m_sdiv [NCH];
    int m_shigh[NCH];
    bit m_pend [NCH];
    bit e_clk  [NCH];
    bit e_tick [NCH];

    clkdiv_bank #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(8), .DEFAULT_HIGH(4)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .wr_high(wr_high),
        .clk_out(clk_out),
        .tick   (tick)
    );

    always #5 clk_in = ~clk_in;

    // Advance the model by one clock. Each period runs from position 0 to
    // div-1. The output bits for this edge come from the position before
    // the edge.
    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            bit w, last;
            int nd;
            if (rst) begin
                m_ph[i] = 0; m_div[i] = 8; m_high[i] = 4; m_pend[i] = 0;
                m_sdiv[i] = 8; m_shigh[i] = 4;
                e_clk[i] = 0; e_tick[i] = 0;
            end else begin
                w    = wr_en && (int'(wr_ch) == i);
                nd   = (int'(wr_div) < 2) ? 2 : int'(wr_div);
                last = (m_ph[i] >= m_div[i] - 1);
                e_clk[i]  = en[i] && (m_ph[i] < m_high[i]);
                e_tick[i] = en[i] && (m_ph[i] == 0);
                if (!en[i] || sync || last) begin
                    if (w) begin
                        m_div[i] = nd; m_high[i] = int'(wr_high);
                    end else if (m_pend[i]) begin
                        m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i];
                    end
                    m_pend[i] = 0;
                    m_ph[i] = 0;
                end else begin
                    if (w) begin
                        m_sdiv[i] = nd; m_shigh[i] = int'(wr_high); m_pend[i] = 1;
                    end
                    m_ph[i] = m_ph[i] + 1;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_in);
        #1;
        cyc_n++;
    endtask

    task automatic do_write(input int ch, input int dv, input int hi);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_div = 8'(dv); wr_high = 8'(hi);
        cyc();
        wr_en = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            total++;
            if (clk_out[i] !== e_clk[i] || tick[i] !== e_tick[i]) begin
                bad++;
                $display("FAIL write ch%0d cyc%0d clk_out=%b tick=%b want %b %b",
                         i, cyc_n, clk_out[i], tick[i], e_clk[i], e_tick[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1; sync = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd3; wr_high = 8'd1;
        cyc();
        cyc();
        total++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            bad++;
            $display("FAIL reset clk_out=%b tick=%b want 0000 0000", clk_out, tick);
        end
        rst = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0;
        cyc();
        total++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle clk_out=%b tick=%b want 0000 0000", clk_out, tick);
        end
    endtask

    task automatic test_default();
        int nt[NCH];
        int nh[NCH];
        for (int i = 0; i < NCH; i++) begin nt[i] = 0; nh[i] = 0; end
        en = '1;
        for (int c = 0; c < 24; c++) begin
            cyc();
            for (int i = 0; i < NCH; i++) begin
                nt[i] += int'(tick[i]);
                nh[i] += int'(clk_out[i]);
                total++;
                if (clk_out[i] !== e_clk[i] || tick[i] !== e_tick[i] || (tick[i] && !clk_out[i])) begin
                    bad++;
                    $display("FAIL default ch%0d cyc%0d clk_out=%b tick=%b want %b %b",
                             i, cyc_n, clk_out[i], tick[i], e_clk[i], e_tick[i]);
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            total++;
            if (nt[i] != 3 || nh[i] != 12) begin
                bad++;
                $display("FAIL default_duty ch%0d ticks=%0d highs=%0d want 3 12", i, nt[i], nh[i]);
            end
        end
    endtask

    task automatic test_write_mid();
        int t1[$];
        int t0[$];
        int h1;
        h1 = 0;
        for (int c = 0; c < 3; c++) cyc();
        do_write(1, 5, 2);
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (tick[1]) t1.push_back(cyc_n);
            if (tick[0]) t0.push_back(cyc_n);
            if (c >= 20) h1 += int'(clk_out[1]);
            for (int i = 0; i < NCH; i++) begin
                total++;
                if (clk_out[i] !== e_clk[i] || tick[i] !== e_tick[i]) begin
                    bad++;
                    $display("FAIL write_mid ch%0d cyc%0d clk_out=%b tick=%b want %b %b",
                             i, cyc_n, clk_out[i], tick[i], e_clk[i], e_tick[i]);
                end
            end
        end
        total++;
        if (t1.size() < 3 || t0.size() < 2 || (t1[$] - t1[$-1]) != 5 || (t0[$] - t0[$-1]) != 8 || h1 != 4) begin
            bad++;
            $display("FAIL write_mid_period ch1_ticks=%0d ch0_ticks=%0d ch1_high=%0d want period 5/8 high 4",
                     t1.size(), t0.size(), h1);
        end
    endtask

    task automatic test_last_write();
        int nt, nh;
        do_write(2, 1, 0);
        do_write(2, 3, 3);
        nt = 0; nh = 0;
        for (int c = 0; c < 24; c++) begin
            cyc();
            if (c >= 12) begin nt += int'(tick[2]); nh += int'(clk_out[2]); end
            total++;
            if (clk_out !== {e_clk[3], e_clk[2], e_clk[1], e_clk[0]} ||
                tick !== {e_tick[3], e_tick[2], e_tick[1], e_tick[0]}) begin
                bad++;
                $display("FAIL last_write cyc%0d clk_out=%b tick=%b", cyc_n, clk_out, tick);
            end
        end
        total++;
        if (nt != 4 || nh != 12) begin
            bad++;
            $display("FAIL last_write_duty ch2 ticks=%0d highs=%0d want 4 12", nt, nh);
        end
        do_write(2, 0, 1);
        nt = 0; nh = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (c >= 10) begin nt += int'(tick[2]); nh += int'(clk_out[2]); end
            total++;
            if (clk_out !== {e_clk[3], e_clk[2], e_clk[1], e_clk[0]} ||
                tick !== {e_tick[3], e_tick[2], e_tick[1], e_tick[0]}) begin
                bad++;
                $display("FAIL clamp cyc%0d clk_out=%b tick=%b", cyc_n, clk_out, tick);
            end
        end
        total++;
        if (nt != 5 || nh != 5) begin
            bad++;
            $display("FAIL clamp_duty ch2 ticks=%0d highs=%0d want 5 5", nt, nh);
        end
    endtask

    task automatic test_sync();
        en = 4'b0111;
        for (int c = 0; c < 3; c++) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        cyc();
        total++;
        if (tick !== 4'b0111 || clk_out !== 4'b0111) begin
            bad++;
            $display("FAIL sync tick=%b clk_out=%b want 0111 0111", tick, clk_out);
        end
        total++;
        if (tick !== {e_tick[3], e_tick[2], e_tick[1], e_tick[0]}) begin
            bad++;
            $display("FAIL sync_model tick=%b", tick);
        end
    endtask

    task automatic test_reenable();
        int nt;
        en = '1;
        cyc();
        do_write(3, 6, 3);
        en = 4'b0111;
        for (int c = 0; c < 10; c++) begin
            cyc();
            total++;
            if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0) begin
                bad++;
                $display("FAIL disabled cyc%0d clk_out3=%b tick3=%b want 0 0", cyc_n, clk_out[3], tick[3]);
            end
        end
        en = '1;
        cyc();
        total++;
        if (clk_out[3] !== 1'b1 || tick[3] !== 1'b1) begin
            bad++;
            $display("FAIL reenable clk_out3=%b tick3=%b want 1 1", clk_out[3], tick[3]);
        end
        nt = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            nt += int'(tick[3]);
            total++;
            if (clk_out[3] !== e_clk[3] || tick[3] !== e_tick[3]) begin
                bad++;
                $display("FAIL reenable_run cyc%0d clk_out3=%b tick3=%b want %b %b",
                         cyc_n, clk_out[3], tick[3], e_clk[3], e_tick[3]);
            end
        end
        total++;
        if (nt != 2) begin
            bad++;
            $display("FAIL reenable_period ticks=%0d want 2", nt);
        end
    endtask

    task automatic test_reset_mid();
        int guard, nt;
        guard = 0;
        while (m_ph[0] != 2 && guard < 20) begin cyc(); guard++; end
        total++;
        if (guard >= 20) begin
            bad++;
            $display("FAIL reset_mid_timeout phase=%0d want 2", m_ph[0]);
        end
        do_write(0, 3, 1);
        rst = 1'b1;
        cyc();
        total++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid clk_out=%b tick=%b want 0000 0000", clk_out, tick);
        end
        rst = 1'b0;
        nt = 0;
        for (int c = 0; c < 17; c++) begin
            cyc();
            nt += int'(tick[0]);
        end
        total++;
        if (nt != 3) begin
            bad++;
            $display("FAIL reset_mid_pending ch0 ticks=%0d want 3", nt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(99) == 0);
            sync    = ($urandom_range(29) == 0);
            wr_en   = ($urandom_range(5) == 0);
            wr_ch   = 2'($urandom_range(3));
            wr_div  = 8'($urandom_range(12));
            wr_high = 8'($urandom_range(13));
            for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(9) != 0);
            cyc();
            for (int i = 0; i < NCH; i++) begin
                total++;
                if (clk_out[i] !== e_clk[i] || tick[i] !== e_tick[i]) begin
                    bad++;
                    $display("FAIL random ch%0d cyc%0d clk_out=%b tick=%b want %b %b",
                             i, cyc_n, clk_out[i], tick[i], e_clk[i], e_tick[i]);
                end
            end
        end
        rst = 1'b0; sync = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0;
        wr_ch = '0; wr_div = '0; wr_high = '0;
        @(negedge clk_in);
        test_reset();
        test_default();
        test_write_mid();
        test_last_write();
        test_sync();
        test_reenable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clkdiv_bank.md
Name: clkdiv_bank

Overview:
- Bank of NUM_CH independent, runtime-programmable clock dividers sharing one fabric clock.
- Generates divided enables and clocks for USB/peripheral logic: one slow clock and one tick per channel.
- Successor to the fixed-divisor divider: per-channel runtime divisor and high-time, glitch-free reprogramming at period boundaries, per-channel enable, global phase-align (sync).

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 8, counter/divisor width in bits (2..16).
- DEFAULT_DIV, 8, active divisor for every channel after reset (2..2^CNT_W-1).
- DEFAULT_HIGH, 4, active high-count for every channel after reset (0..DEFAULT_DIV).

Ports:
- clk_in  input  1  fabric clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel run enable.
- sync  input  1  realign all channel counters to period start.
- wr_en  input  1  config write strobe, single cycle, no backpressure.
- wr_ch  input  clog2(NUM_CH) (min 1)  target channel; values >= NUM_CH are ignored.
- wr_div  input  CNT_W  new divisor (period in clk_in cycles).
- wr_high  input  CNT_W  new high-count (clk_out high cycles per period).
- clk_out  output  NUM_CH  registered divided clock per channel.
- tick  output  NUM_CH  registered one-cycle pulse at each period start.

Behaviour:
- Per channel state:
  - cnt[CNT_W]
  - act_div, act_high (active configuration)
  - sh_div, sh_high, pend (shadow configuration and pending flag)
- Reset (rst=1 at an edge):
  - cnt=0, act_div=DEFAULT_DIV, act_high=DEFAULT_HIGH, pend=0, clk_out=0, tick=0.
  - rst overrides all other inputs in that cycle.
- Write:
  - Divisor clamping: wr_div values 0 and 1 are stored as 2.
  - The clamped div and wr_high go to the channel's shadow registers; pend is set.
  - A later write before the boundary overwrites the shadow (last write wins).
  - act_* is never changed mid-period.
- Boundary:
  - A boundary cycle is one where en=1 and (cnt >= act_div-1, or sync=1), or where en=0.
  - At a boundary, if pend=1 (or a write to this channel occurs in the same cycle): act_* <= newest value (same-cycle write wins over shadow), pend <= 0.
- Counter (en=1):
  - Next cnt = 0 if sync=1 or cnt >= act_div-1; otherwise cnt+1.
  - sync has priority over wrap.
- Counter (en=0): cnt <= 0.
- Outputs (registered, one-cycle latency from cnt):
  - clk_out[i] <= en[i] && (cnt < act_high).
  - tick[i] <= en[i] && (cnt == 0).
  - act_high=0: clk_out constant 0.
  - act_high >= act_div: clk_out constant 1 while enabled.
  - tick still pulses once per period in both of these cases.
- Period and duty:
  - Period = act_div cycles; high = min(act_high, act_div) cycles.
  - First high cycle coincides with tick.
- Re-enable timing: en 0->1 at edge E gives tick=1 and clk_out=1 (if act_high>0) in the cycle after E.
- sync: asserted at edge E, every enabled channel shows tick in cycle E+2. sync held high keeps cnt at 0, so tick stays high.
- Reset mid-period: behaves as a power-on reset; pending writes are discarded.
- Counter arithmetic wraps at CNT_W. The cnt >= act_div-1 test makes any out-of-range cnt recover within one cycle.

Test Plan:
- Reset defaults, all en=1, NUM_CH=4, CNT_W=8 -> each clk_out shows 4 cycles high / 4 low; tick one cycle every 8 cycles, coincident with clk_out rise.
- Write ch1 div=5 high=2 mid-period (cnt=3) -> ch1 finishes the 8-cycle period, then runs 2 high / 3 low; other channels unaffected.
- Write ch2 div=1 high=0, then div=3 high=3 before the boundary -> last write wins; period 3, clk_out constant 1, tick every 3 cycles. Separately, div=0 is clamped to period 2.
- Channels at different phases, pulse sync for 1 cycle -> two cycles later all enabled ticks assert in the same cycle; a channel with en=0 stays low.
- en[3] low for 10 cycles, then high -> clk_out[3]/tick[3] low while disabled; tick and clk_out high in the cycle after en rises; pending config applied.
- rst asserted mid-period with pend=1 -> next cycle all outputs 0, defaults restored, and the pending write never takes effect.
